// File: rtl/sopc_nios2_0_mul_issue.sv
// Issue/return wrapper for the Nios II 32x32 low-word multiply cell.
// Credit-limited issue, a fixed-latency valid/tag pipe, and an in-order result FIFO.
module sopc_nios2_0_mul_issue #(
  parameter int MUL_LATENCY = 1,
  parameter int FIFO_DEPTH  = 2,
  parameter int TAG_W       = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_src1,
  input  logic [31:0]      req_src2,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      cell_src1,
  output logic [31:0]      cell_src2,
  input  logic [31:0]      cell_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
);

  // Handshakes: a transfer happens on a rising clk edge where valid & ready are both 1.
  // req_ready and rsp_valid come from registered state only; valid never waits on ready.

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = $clog2(MUL_LATENCY + FIFO_DEPTH + 1);

  logic                   ready_en;
  logic [MUL_LATENCY-1:0] vld;
  logic [TAG_W-1:0]       tag_pipe    [MUL_LATENCY];
  logic [31:0]            fifo_result [FIFO_DEPTH];
  logic [TAG_W-1:0]       fifo_tag    [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       fifo_count;
  logic [OCC_W-1:0]       occupancy;
  logic                   accept;
  logic                   capture;
  logic                   pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) next_ptr = '0;
    else                              next_ptr = p + 1'b1;
  endfunction

  // A slot stays counted until its pop edge, so back-to-back issue with
  // rsp_ready held high needs FIFO_DEPTH >= MUL_LATENCY+2.
  always_comb begin
    occupancy = OCC_W'(fifo_count);
    for (int i = 0; i < MUL_LATENCY; i++) begin
      occupancy = occupancy + OCC_W'(vld[i]);
    end
  end

  assign req_ready  = ready_en & (occupancy < OCC_W'(FIFO_DEPTH));
  assign accept     = req_valid & req_ready;
  assign capture    = vld[MUL_LATENCY-1];
  assign pop        = rsp_valid & rsp_ready;
  assign cell_src1  = req_src1;
  assign cell_src2  = req_src2;
  assign rsp_valid  = (fifo_count != '0);
  assign rsp_result = fifo_result[rd_ptr];
  assign rsp_tag    = fifo_tag[rd_ptr];
  assign busy       = (occupancy != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_en <= 1'b0;
      vld      <= '0;
      for (int i = 0; i < MUL_LATENCY; i++) tag_pipe[i] <= '0;
    end else begin
      ready_en    <= 1'b1;
      vld[0]      <= accept;
      tag_pipe[0] <= req_tag;
      for (int i = 1; i < MUL_LATENCY; i++) begin
        vld[i]      <= vld[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_result[i] <= '0;
        fifo_tag[i]    <= '0;
      end
    end else begin
      if (capture) begin
        fifo_result[wr_ptr] <= cell_result;
        fifo_tag[wr_ptr]    <= tag_pipe[MUL_LATENCY-1];
        wr_ptr              <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      case ({capture, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Credit must keep a capture from ever landing on a full FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(capture && !pop && (fifo_count == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_sopc_nios2_0_mul_issue.sv
// Directed bench for sopc_nios2_0_mul_issue: vector table plus hand-written
// latency, streaming, backpressure, full push+pop and async-reset sequences.
module tb_sopc_nios2_0_mul_issue;

  localparam int LAT   = 1;
  localparam int DEPTH = 3;
  localparam int TW    = 4;

  typedef struct {
    logic [31:0]   src1;
    logic [31:0]   src2;
    logic [TW-1:0] tag;
    logic [31:0]   exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [31:0]   req_src1 = '0;
  logic [31:0]   req_src2 = '0;
  logic [TW-1:0] req_tag = '0;
  logic [31:0]   cell_src1;
  logic [31:0]   cell_src2;
  logic [31:0]   cell_result;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [31:0]   rsp_result;
  logic [TW-1:0] rsp_tag;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic [TW+31:0] exp_q[$];
  vec_t tab[13];
  bit stream_mode = 0;
  int stream_pops = 0;
  int stream_first = 0;
  int stream_last = 0;

  sopc_nios2_0_mul_issue #(
    .MUL_LATENCY(LAT),
    .FIFO_DEPTH (DEPTH),
    .TAG_W      (TW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_src1   (req_src1),
    .req_src2   (req_src2),
    .req_tag    (req_tag),
    .cell_src1  (cell_src1),
    .cell_src2  (cell_src2),
    .cell_result(cell_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_tag    (rsp_tag),
    .busy       (busy)
  );

  // Clock / reset-free cell model: one-cycle registered low-word multiply.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) cell_result <= cell_src1 * cell_src2;

  task automatic check(input string name, input logic [TW+31:0] act, input logic [TW+31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: responses must match the head of exp_q; held heads must not move.
  always @(negedge clk) begin
    if (reset_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_rsp: got tag=%0d result=%h required no response", rsp_tag, rsp_result);
      end else begin
        check(rsp_ready ? "rsp_data" : "rsp_hold", {rsp_tag, rsp_result}, exp_q[0]);
        if (rsp_ready) begin
          void'(exp_q.pop_front());
          if (stream_mode) begin
            if (stream_pops == 0) stream_first = cyc;
            stream_last = cyc;
            stream_pops++;
          end
        end
      end
    end
  end

  // Driver: called just after a rising edge; returns just after the accept edge.
  task automatic send(input vec_t v, output int stalls);
    bit acc = 0;
    stalls = 0;
    req_valid = 1'b1;
    req_src1  = v.src1;
    req_src2  = v.src2;
    req_tag   = v.tag;
    for (int k = 0; k < 64 && !acc; k++) begin
      @(negedge clk);
      if (req_ready) begin
        exp_q.push_back({v.tag, v.exp});
        acc = 1;
      end else begin
        stalls++;
      end
    end
    check("req_accepted", {35'd0, acc}, 36'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 40 && (exp_q.size() != 0 || busy); k++) @(negedge clk);
    check("drain_sb_empty", 36'(exp_q.size()), 36'd0);
    check("drain_busy", {35'd0, busy}, 36'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int st;
    int accepts;
    int bi;
    int seen;
    vec_t one;

    tab[0]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 4'd0,  32'h00000001};
    tab[1]  = '{32'h00010001, 32'h00010001, 4'd1,  32'h00020001};
    tab[2]  = '{32'h00000000, 32'h12345678, 4'd2,  32'h00000000};
    tab[3]  = '{32'h80000000, 32'h00000002, 4'd3,  32'h00000000};
    tab[4]  = '{32'h12345678, 32'h00000001, 4'd4,  32'h12345678};
    tab[5]  = '{32'h0000FFFF, 32'h0000FFFF, 4'd5,  32'hFFFE0001};
    tab[6]  = '{32'h00010000, 32'h00010000, 4'd6,  32'h00000000};
    tab[7]  = '{32'hFFFFFFFF, 32'h00000002, 4'd7,  32'hFFFFFFFE};
    tab[8]  = '{32'h00000100, 32'h00000100, 4'd8,  32'h00010000};
    tab[9]  = '{32'hDEADBEEF, 32'h00000001, 4'd9,  32'hDEADBEEF};
    tab[10] = '{32'h80000001, 32'h80000001, 4'd10, 32'h00000001};
    tab[11] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 4'd11, 32'h00000004};
    tab[12] = '{32'h00000003, 32'hFFFFFFFF, 4'd12, 32'hFFFFFFFD};

    // Reset values and the ready_en edge.
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", {35'd0, req_ready}, 36'd0);
    check("rst_rsp_valid", {35'd0, rsp_valid}, 36'd0);
    check("rst_busy", {35'd0, busy}, 36'd0);
    check("rst_rsp_result", {4'd0, rsp_result}, 36'd0);
    check("rst_rsp_tag", 36'(rsp_tag), 36'd0);
    #2 reset_n = 1'b1;
    #1 check("ready_before_edge", {35'd0, req_ready}, 36'd0);
    @(posedge clk); #1;
    check("ready_after_edge", {35'd0, req_ready}, 36'd1);

    // Single op: accept in cycle t, response visible in cycle t+2.
    rsp_ready = 1'b1;
    one = '{32'd3, 32'd5, 4'd1, 32'h0000000F};
    send(one, st);
    @(negedge clk);
    check("lat_valid_t1", {35'd0, rsp_valid}, 36'd0);
    check("lat_busy_t1", {35'd0, busy}, 36'd1);
    @(negedge clk);
    check("lat_valid_t2", {35'd0, rsp_valid}, 36'd1);
    check("lat_result", {4'd0, rsp_result}, 36'h00000000F);
    check("lat_tag", 36'(rsp_tag), 36'd1);
    @(posedge clk); #1;
    wait_drain();

    // Streaming: table vectors back-to-back, tags 0..7.
    stream_mode = 1;
    stream_pops = 0;
    for (int i = 0; i < 8; i++) begin
      send(tab[i], st);
      check("stream_stall", 36'(st), 36'd0);
      req_valid = 1'b1;
    end
    req_valid = 1'b0;
    wait_drain();
    stream_mode = 0;
    check("stream_count", 36'(stream_pops), 36'd8);
    check("stream_span", 36'(stream_last - stream_first), 36'd7);

    // Backpressure: rsp_ready low, req_valid held -> exactly DEPTH accepts.
    rsp_ready = 1'b0;
    bi = 8;
    accepts = 0;
    req_valid = 1'b1;
    req_src1 = tab[bi].src1; req_src2 = tab[bi].src2; req_tag = tab[bi].tag;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (req_ready) begin
        exp_q.push_back({tab[bi].tag, tab[bi].exp});
        accepts++;
        bi++;
      end
      @(posedge clk); #1;
      req_src1 = tab[bi].src1; req_src2 = tab[bi].src2; req_tag = tab[bi].tag;
    end
    check("bp_accepts", 36'(accepts), 36'(DEPTH));
    @(negedge clk);
    check("bp_ready_low", {35'd0, req_ready}, 36'd0);
    check("bp_rsp_valid", {35'd0, rsp_valid}, 36'd1);
    check("bp_busy", {35'd0, busy}, 36'd1);
    @(posedge clk); #1;

    // Full FIFO, release rsp_ready: ready rises next cycle, then accept+pop overlap.
    rsp_ready = 1'b1;
    @(negedge clk);
    check("full_ready_still_low", {35'd0, req_ready}, 36'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("full_ready_rise", {35'd0, req_ready}, 36'd1);
    exp_q.push_back({tab[11].tag, tab[11].exp});
    @(posedge clk); #1;
    req_src1 = tab[12].src1; req_src2 = tab[12].src2; req_tag = tab[12].tag;
    @(negedge clk);
    check("full_ready_hold", {35'd0, req_ready}, 36'd1);
    if (req_ready) exp_q.push_back({tab[12].tag, tab[12].exp});
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_drain();

    // Async reset with two ops in flight: outputs clear without a clock edge.
    rsp_ready = 1'b0;
    send(tab[4], st);
    send(tab[5], st);
    check("pre_reset_valid", {35'd0, rsp_valid}, 36'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rsp_valid", {35'd0, rsp_valid}, 36'd0);
    check("async_busy", {35'd0, busy}, 36'd0);
    check("async_req_ready", {35'd0, req_ready}, 36'd0);
    check("async_rsp_result", {4'd0, rsp_result}, 36'd0);
    exp_q.delete();
    @(negedge clk);
    #2 reset_n = 1'b1;
    #1 check("rel_ready_before_edge", {35'd0, req_ready}, 36'd0);
    @(posedge clk); #1;
    check("rel_ready_after_edge", {35'd0, req_ready}, 36'd1);
    rsp_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("no_stale_rsp", 36'(seen), 36'd0);
    check("final_sb_empty", 36'(exp_q.size()), 36'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
